tick_sched: RTL

Runtime-programmable timebase scheduler for the 100 MHz fabric clock. It owns one free-running counter per channel and issues single-cycle `tick` enable strobes at software-set periods, so game logic, the display scan and input sampling all run on `clk` with enables instead of derived clocks. A small valid/ready configuration port lets the game controller retune or disable any channel while the others keep running.

---
 rtl/tick_sched.sv | 114 +++++++++++
 1 files changed

// File: rtl/tick_sched.sv
// Per-channel programmable tick strobes with a two-state valid/ready config port.
// Optional TICK_SCHED_TOGGLE_EN adds a 50% square wave output per channel.
module tick_sched #(
  parameter int NCH = 4,
  parameter int CW  = 27
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   run,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  input  logic [$clog2(NCH)-1:0] cfg_ch,
  input  logic [CW-1:0]          cfg_period,
  output logic [NCH-1:0]         tick
`ifdef TICK_SCHED_TOGGLE_EN
  ,
  output logic [NCH-1:0]         sq
`endif
);

  localparam int CHW = $clog2(NCH);

  typedef enum logic {
    IDLE  = 1'b0,
    APPLY = 1'b1
  } state_t;

  state_t         state_q, state_d;
  logic [CHW-1:0] ch_q, ch_d;
  logic [CW-1:0]  lat_per_q, lat_per_d;

  logic [CW-1:0]  period_q [NCH];
  logic [CW-1:0]  period_d [NCH];
  logic [CW-1:0]  cnt_q    [NCH];
  logic [CW-1:0]  cnt_d    [NCH];
  logic [NCH-1:0] tick_q, tick_d;
  logic [NCH-1:0] sq_q, sq_d;

  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    lat_per_d = lat_per_q;
    cfg_ready = 1'b0;
    case (state_q)
      IDLE: begin
        cfg_ready = 1'b1;
        if (cfg_valid) begin
          ch_d      = cfg_ch;
          lat_per_d = cfg_period;
          state_d   = APPLY;
        end
      end
      APPLY:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // An apply to a channel overrides its wrap; out-of-range channels match nothing.
  always_comb begin
    tick_d = '0;
    sq_d   = sq_q;
    for (int i = 0; i < NCH; i++) begin
      period_d[i] = period_q[i];
      cnt_d[i]    = cnt_q[i];
      if (state_q == APPLY && int'(ch_q) == i) begin
        period_d[i] = lat_per_q;
        cnt_d[i]    = '0;
        sq_d[i]     = 1'b0;
      end else if (run && period_q[i] != '0) begin
        if (cnt_q[i] == period_q[i] - CW'(1)) begin
          cnt_d[i]  = '0;
          tick_d[i] = 1'b1;
          sq_d[i]   = ~sq_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ch_q      <= '0;
      lat_per_q <= '0;
      tick_q    <= '0;
      sq_q      <= '0;
      for (int i = 0; i < NCH; i++) begin
        period_q[i] <= '0;
        cnt_q[i]    <= '0;
      end
    end else begin
      state_q   <= state_d;
      ch_q      <= ch_d;
      lat_per_q <= lat_per_d;
      tick_q    <= tick_d;
      sq_q      <= sq_d;
      for (int i = 0; i < NCH; i++) begin
        period_q[i] <= period_d[i];
        cnt_q[i]    <= cnt_d[i];
      end
    end
  end

  assign tick = tick_q;

`ifdef TICK_SCHED_TOGGLE_EN
  assign sq = sq_q;
`else
  logic unused_sq;
  assign unused_sq = ^sq_q;
`endif

endmodule
